// File: rtl/cg_ctrl.sv
// Clock-gate controller: turns a level clock-on request into an idle handshake,
// a hold window before gating, and a fixed wake window before release.
module cg_ctrl #(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int WAKE_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_req_i,
    input  logic idle_ack_i,
    input  logic timeout_clr_i,
    output logic cg_en_o,
    output logic idle_req_o,
    output logic status_on_o,
    output logic busy_o,
    output logic timeout_o
);

    typedef enum logic [2:0] {
        ST_ON,
        ST_REQ_IDLE,
        ST_HOLD,
        ST_OFF,
        ST_WAKE
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LD     = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LD     = CNT_W'(WAKE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W:0]   TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             timeout_set;
    logic [CNT_W-1:0] cnt_inc, cnt_dec;
    logic [CNT_W:0]   wait_next;
    logic             cg_en_q, idle_req_q, status_on_q, busy_q;

    // One counter serves as the REQ_IDLE wait timer and the HOLD/WAKE countdown.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign cnt_dec   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    assign wait_next = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_set = 1'b0;
        case (state_q)
            ST_ON: begin
                if (!en_req_i) begin
                    state_d = ST_REQ_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_REQ_IDLE: begin
                if (en_req_i) begin
                    state_d = ST_ON;
                end else if (idle_ack_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (wait_next >= TIMEOUT_LIM)) begin
                        state_d     = ST_ON;
                        timeout_set = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (en_req_i) begin
                    state_d = ST_ON;
                end else if (!idle_ack_i) begin
                    state_d = ST_REQ_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_OFF: begin
                if (en_req_i) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LD;
                end
            end
            ST_WAKE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        endcase
    end

    // Set takes priority over clear when both happen in the same cycle.
    assign timeout_d = timeout_set ? 1'b1 : (timeout_clr_i ? 1'b0 : timeout_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ON;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            cg_en_q     <= 1'b1;
            idle_req_q  <= 1'b0;
            status_on_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            cg_en_q     <= (state_d != ST_OFF);
            idle_req_q  <= (state_d != ST_ON);
            status_on_q <= (state_d == ST_ON);
            busy_q      <= (state_d == ST_REQ_IDLE) || (state_d == ST_HOLD)
                           || (state_d == ST_WAKE);
        end
    end

    assign cg_en_o     = cg_en_q;
    assign idle_req_o  = idle_req_q;
    assign status_on_o = status_on_q;
    assign busy_o      = busy_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cg_ctrl.sv
// Bench for cg_ctrl: two instances with different hold/wake/timeout settings
// driven by shared directed stimulus, checked against a phase model every cycle.
module tb_cg_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en_req = 1'b1;
    logic idle_ack = 1'b0;
    logic timeout_clr = 1'b0;
    logic [1:0] cg_en, idle_req, status_on, busy, timeout;

    int n_tests = 0;
    int n_fail = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    cg_ctrl #(.CNT_W(8), .HOLD_CYCLES(2), .WAKE_CYCLES(4), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en_req_i(en_req), .idle_ack_i(idle_ack),
        .timeout_clr_i(timeout_clr), .cg_en_o(cg_en[0]), .idle_req_o(idle_req[0]),
        .status_on_o(status_on[0]), .busy_o(busy[0]), .timeout_o(timeout[0]));

    cg_ctrl #(.CNT_W(8), .HOLD_CYCLES(5), .WAKE_CYCLES(3), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en_req_i(en_req), .idle_ack_i(idle_ack),
        .timeout_clr_i(timeout_clr), .cg_en_o(cg_en[1]), .idle_req_o(idle_req[1]),
        .status_on_o(status_on[1]), .busy_o(busy[1]), .timeout_o(timeout[1]));

    // ---------------- behavioural model ----------------
    localparam int P_ON = 0, P_REQ = 1, P_HOLD = 2, P_OFF = 3, P_WAKE = 4;
    int m_ph [2];
    int m_n  [2];   // REQ: cycles waited so far; HOLD/WAKE: cycles left
    bit m_to [2];

    function automatic int hold_of(int i); return (i == 0) ? 2 : 5; endfunction
    function automatic int wake_of(int i); return (i == 0) ? 4 : 3; endfunction
    function automatic int tmo_of(int i);  return (i == 0) ? 8 : 0; endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] <= P_ON;
                m_n[i]  <= 0;
                m_to[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_to[i] <= timeout_clr ? 1'b0 : m_to[i];
                case (m_ph[i])
                    P_ON: if (!en_req) begin m_ph[i] <= P_REQ; m_n[i] <= 0; end
                    P_REQ: begin
                        if (en_req) m_ph[i] <= P_ON;
                        else if (idle_ack) begin m_ph[i] <= P_HOLD; m_n[i] <= hold_of(i); end
                        else if (tmo_of(i) != 0 && m_n[i] + 1 >= tmo_of(i)) begin
                            m_ph[i] <= P_ON;
                            m_to[i] <= 1'b1;
                        end else m_n[i] <= m_n[i] + 1;
                    end
                    P_HOLD: begin
                        if (en_req) m_ph[i] <= P_ON;
                        else if (!idle_ack) begin m_ph[i] <= P_REQ; m_n[i] <= 0; end
                        else if (m_n[i] == 1) m_ph[i] <= P_OFF;
                        else m_n[i] <= m_n[i] - 1;
                    end
                    P_OFF: if (en_req) begin m_ph[i] <= P_WAKE; m_n[i] <= wake_of(i); end
                    default: begin
                        if (m_n[i] == 1) m_ph[i] <= P_ON;
                        else m_n[i] <= m_n[i] - 1;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] t=%0t actual=%b required=%b", name, idx, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int i = 0; i < 2; i++) begin
                chk("cmp_cg_en", i, cg_en[i], m_ph[i] != P_OFF);
                chk("cmp_idle_req", i, idle_req[i], m_ph[i] != P_ON);
                chk("cmp_status_on", i, status_on[i], m_ph[i] == P_ON);
                chk("cmp_busy", i, busy[i], m_ph[i] == P_REQ || m_ph[i] == P_HOLD || m_ph[i] == P_WAKE);
                chk("cmp_timeout", i, timeout[i], m_to[i]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cg_en", i, cg_en[i], 1'b1);
            chk("rst_idle_req", i, idle_req[i], 1'b0);
            chk("rst_status_on", i, status_on[i], 1'b1);
            chk("rst_busy", i, busy[i], 1'b0);
            chk("rst_timeout", i, timeout[i], 1'b0);
        end
        run_cmp = 1'b1;
        @(negedge clk) rst_n = 1'b1;

        // 1: steady ON
        repeat (20) @(negedge clk);
        chk("t1_cg_en", 0, cg_en[0], 1'b1);
        chk("t1_idle_req", 0, idle_req[0], 1'b0);
        chk("t1_busy", 0, busy[0], 1'b0);

        // 2: gate off; en_req low sampled at edge k, idle_ack from k+1
        en_req = 1'b0;
        @(negedge clk);
        chk("t2_idle_req_k", 0, idle_req[0], 1'b1);
        chk("t2_busy_k", 0, busy[0], 1'b1);
        idle_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_cg_en_k2", 0, cg_en[0], 1'b1);
        @(negedge clk);
        chk("t2_cg_en_k3", 0, cg_en[0], 1'b0);
        chk("t2_status_k3", 0, status_on[0], 1'b0);
        chk("t2_idle_req_k3", 0, idle_req[0], 1'b1);
        repeat (4) @(negedge clk);
        chk("t2_cg_en_hold5", 1, cg_en[1], 1'b0);

        // 3: wake from OFF, en_req glitch in WAKE ignored
        en_req = 1'b1;
        @(negedge clk);
        chk("t3_cg_en_w", 0, cg_en[0], 1'b1);
        chk("t3_idle_req_w", 0, idle_req[0], 1'b1);
        chk("t3_status_w", 0, status_on[0], 1'b0);
        idle_ack = 1'b0;
        @(negedge clk) en_req = 1'b0;
        @(negedge clk) en_req = 1'b1;
        @(negedge clk);
        chk("t3_idle_req_w3", 0, idle_req[0], 1'b1);
        @(negedge clk);
        chk("t3_idle_req_w4", 0, idle_req[0], 1'b0);
        chk("t3_status_w4", 0, status_on[0], 1'b1);
        chk("t3_busy_w4", 0, busy[0], 1'b0);

        // 4: timeout after 8 REQ_IDLE cycles, clear, then set-beats-clear
        en_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("t4_status_k7", 0, status_on[0], 1'b0);
        chk("t4_timeout_k7", 0, timeout[0], 1'b0);
        @(negedge clk);
        chk("t4_status_k8", 0, status_on[0], 1'b1);
        chk("t4_timeout_k8", 0, timeout[0], 1'b1);
        chk("t4_wait_forever", 1, busy[1], 1'b1);
        timeout_clr = 1'b1;
        @(negedge clk);
        chk("t4_cleared", 0, timeout[0], 1'b0);
        repeat (7) @(negedge clk);
        chk("t4_timeout_k16", 0, timeout[0], 1'b0);
        @(negedge clk);
        chk("t4_set_wins", 0, timeout[0], 1'b1);
        en_req = 1'b1;
        @(negedge clk);
        chk("t4_clr_next", 0, timeout[0], 1'b0);
        chk("t4_abort_b", 1, status_on[1], 1'b1);
        timeout_clr = 1'b0;

        // 5: idle_ack drops during HOLD, then abort with en_req
        en_req = 1'b0;
        @(negedge clk) idle_ack = 1'b1;
        @(negedge clk);
        @(negedge clk) idle_ack = 1'b0;
        @(negedge clk);
        chk("t5_cg_en_req", 1, cg_en[1], 1'b1);
        chk("t5_busy_req", 1, busy[1], 1'b1);
        chk("t5_status_req", 1, status_on[1], 1'b0);
        idle_ack = 1'b1;
        @(negedge clk);
        idle_ack = 1'b0;
        en_req = 1'b1;
        @(negedge clk);
        chk("t5_idle_req_on", 1, idle_req[1], 1'b0);
        chk("t5_status_on", 1, status_on[1], 1'b1);

        // abort in REQ_IDLE beats a simultaneous idle_ack
        en_req = 1'b0;
        @(negedge clk);
        en_req = 1'b1;
        idle_ack = 1'b1;
        @(negedge clk);
        chk("t5_abort_prio", 0, idle_req[0], 1'b0);
        chk("t5_abort_busy", 0, busy[0], 1'b0);
        idle_ack = 1'b0;

        // 6: async reset while OFF
        en_req = 1'b0;
        idle_ack = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_off_a", 0, cg_en[0], 1'b0);
        chk("t6_off_b", 1, cg_en[1], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("t6_cg_en", i, cg_en[i], 1'b1);
            chk("t6_idle_req", i, idle_req[i], 1'b0);
            chk("t6_timeout", i, timeout[i], 1'b0);
            chk("t6_status", i, status_on[i], 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en_req = 1'b1;
        idle_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_after_a", 0, status_on[0], 1'b1);
        chk("t6_after_b", 1, status_on[1], 1'b1);

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
